// File: rtl/cache_refill_ctrl_pkg.sv
// cache_pkg: shared widths, packed cache-line layout and refill FSM state
// encoding for cache_refill_ctrl and its line-assembly buffer.
//   LINE_WIDTH  : 1 valid + TAG_WIDTH tag + LINE_WORDS*WORD_WIDTH data = 153
//   cache_line_t: {valid, tag, w3, w2, w1, w0}
package cache_pkg;

    localparam int TAG_WIDTH      = 24;
    localparam int SET_WIDTH      = 4;
    localparam int OFFSET_WIDTH   = 4;
    localparam int WORD_IDX_WIDTH = 2;
    localparam int LINE_WORDS     = 4;
    localparam int WORD_WIDTH     = 32;
    localparam int LINE_WIDTH     = 1 + TAG_WIDTH + LINE_WORDS * WORD_WIDTH;

    typedef struct packed {
        logic                                  valid;
        logic [TAG_WIDTH-1:0]                  tag;
        logic [LINE_WORDS-1:0][WORD_WIDTH-1:0] words;
    } cache_line_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DONE  = 2'd3
    } refill_state_t;

    // Word index inside a line wraps modulo 4.
    function automatic logic [WORD_IDX_WIDTH-1:0] next_word(input logic [WORD_IDX_WIDTH-1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_line_buf.sv
// refill_line_buf: four-word assembly register for one cache line.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero all slots (start of a new refill)
//   wr_en      : write wr_data into slot wr_idx
//   wr_idx     : target word slot 0..3
//   wr_data    : memory word
//   line       : {w3, w2, w1, w0}
module refill_line_buf
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [1:0]              wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [4*DATA_WIDTH-1:0] line
);

    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] words_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else if (clr) begin
            words_q <= '0;
        end else if (wr_en) begin
            words_q[wr_idx] <= wr_data;
        end
    end

    assign line = words_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: fetches a 4-word cache line from backing RAM one word
// at a time (single outstanding request) and presents the assembled line.
// Optional macro CRITICAL_WORD_FIRST_EN: start at the missing word, wrap,
// and pulse crit_valid/crit_data after the first response.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   miss_req, miss_addr : miss request, sampled only in IDLE
//   busy                : high outside IDLE
//   mem_req_valid/addr/ready : word read request handshake
//   mem_rsp_valid/data  : read response, consumed only in RESP
//   fill_valid/set/line : one-cycle line-complete pulse and payload
//   crit_valid/data     : early requested-word pulse (0 unless macro defined)
//
// state    | meaning
// ST_IDLE  | waiting for miss_req
// ST_ISSUE | mem_req_valid held until mem_req_ready
// ST_RESP  | waiting for mem_rsp_valid of the outstanding word
// ST_DONE  | fill_valid pulse, back to IDLE
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_req,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  busy,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  fill_valid,
    output logic [SET_BITS-1:0]   fill_set,
    output logic [LINE_WIDTH-1:0] fill_line,
    output logic                  crit_valid,
    output logic [DATA_WIDTH-1:0] crit_data
);

    localparam int TAG_W = ADDR_WIDTH - 8;

    refill_state_t        state;
    logic [TAG_W-1:0]     tag_q;
    logic [SET_BITS-1:0]  set_q;
    logic [1:0]           word_idx;
    logic [1:0]           word_cnt;
    logic                 last_word;
    logic [1:0]           start_idx;
    logic                 buf_clr;
    logic                 buf_wr;
    logic [4*DATA_WIDTH-1:0]               buf_line;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] merged;
    cache_line_t          line_next;
    logic                 unused_addr_bits;

    // Byte offset within a word never affects the refill.
    assign unused_addr_bits = ^miss_addr[3:0];

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_idx = miss_addr[3:2];
`else
    assign start_idx = 2'b00;
`endif

    assign mem_req_addr = {tag_q, set_q, word_idx, 2'b00};
    assign last_word    = (word_cnt == 2'd3);
    assign buf_clr      = (state == ST_IDLE) && miss_req;
    assign buf_wr       = (state == ST_RESP) && mem_rsp_valid;

    refill_line_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_idx  (word_idx),
        .wr_data (mem_rsp_data),
        .line    (buf_line)
    );

    // The final word is written into the buffer on the same edge that
    // registers fill_line, so it is merged in here rather than read back.
    always_comb begin
        merged           = buf_line;
        merged[word_idx] = mem_rsp_data;
        line_next.valid  = 1'b1;
        line_next.tag    = tag_q;
        line_next.words  = merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tag_q         <= '0;
            set_q         <= '0;
            word_idx      <= '0;
            word_cnt      <= '0;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            fill_valid    <= 1'b0;
            fill_set      <= '0;
            fill_line     <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_valid    <= 1'b0;
            crit_data     <= '0;
`endif
        end else begin
            fill_valid <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_valid <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (miss_req) begin
                        tag_q         <= miss_addr[ADDR_WIDTH-1 -: TAG_W];
                        set_q         <= miss_addr[4 +: SET_BITS];
                        word_idx      <= start_idx;
                        word_cnt      <= '0;
                        busy          <= 1'b1;
                        mem_req_valid <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rsp_valid) begin
`ifdef CRITICAL_WORD_FIRST_EN
                        if (word_cnt == 2'd0) begin
                            crit_valid <= 1'b1;
                            crit_data  <= mem_rsp_data;
                        end
`endif
                        if (last_word) begin
                            fill_valid <= 1'b1;
                            fill_set   <= set_q;
                            fill_line  <= line_next;
                            state      <= ST_DONE;
                        end else begin
                            word_cnt      <= word_cnt + 2'd1;
                            word_idx      <= next_word(word_idx);
                            mem_req_valid <= 1'b1;
                            state         <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef CRITICAL_WORD_FIRST_EN
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

    logic         clk;
    logic         rst_n;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         fill_valid;
    logic [3:0]   fill_set;
    logic [152:0] fill_line;
    logic         crit_valid;
    logic [31:0]  crit_data;

    int n_checks = 0;
    int n_fail   = 0;

    cache_refill_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_req      (miss_req),
        .miss_addr     (miss_addr),
        .busy          (busy),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_valid    (fill_valid),
        .fill_set      (fill_set),
        .fill_line     (fill_line),
        .crit_valid    (crit_valid),
        .crit_data     (crit_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: word content equals its address; data follows the most
    // recently accepted request.
    logic [31:0] last_addr = 32'h0;
    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) last_addr <= mem_req_addr;
    end
    assign mem_rsp_data = last_addr;

    typedef struct packed {
        logic [31:0]       addr;
        logic [7:0]        stall_idx;
        logic [7:0]        stall_len;
        logic [7:0]        exp_cyc;
        logic [3:0]        exp_set;
        logic [152:0]      exp_line;
        logic [3:0][31:0]  exp_req;
        logic [31:0]       exp_crit;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [152:0] act, input logic [152:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_refill(input vec_t v, input bit hold, input logic [31:0] alt_addr,
                              input logic [31:0] alt_exp_req);
        int hs, stall_cnt, fills, fill_cyc, crits, crit_cyc, unstable;
        logic [31:0]  reqs [4];
        logic [31:0]  prev_addr;
        logic         prev_valid;
        logic [152:0] got_line;
        logic [3:0]   got_set;
        logic [31:0]  got_crit;
        hs = 0; stall_cnt = 0; fills = 0; fill_cyc = 0; crits = 0; crit_cyc = 0; unstable = 0;
        prev_valid = 1'b0; prev_addr = '0; got_line = '0; got_set = '0; got_crit = '0;
        for (int k = 0; k < 4; k++) reqs[k] = '0;
        @(negedge clk);
        miss_req = 1'b1; miss_addr = v.addr; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (hold) miss_addr = alt_addr;
                else miss_req = 1'b0;
                check("busy_after_accept", 153'(busy), 153'(1));
            end
            if (fill_cyc > 0 && cyc == fill_cyc + 1) begin
                check("busy_clear_after_done", 153'(busy), 153'(0));
                check("fill_pulse_one_cycle", 153'(fill_valid), 153'(0));
                if (!hold) break;
            end
            if (hold && fill_cyc > 0 && cyc == fill_cyc + 2) begin
                check("new_miss_busy", 153'(busy), 153'(1));
                check("new_miss_req_valid", 153'(mem_req_valid), 153'(1));
                check("new_miss_req_addr", 153'(mem_req_addr), 153'(alt_exp_req));
                break;
            end
            if (fill_valid) begin
                fills++; fill_cyc = cyc; got_line = fill_line; got_set = fill_set;
            end
            if (crit_valid) begin
                crits++; crit_cyc = cyc; got_crit = crit_data;
            end
            if (mem_req_valid && prev_valid && mem_req_addr != prev_addr) unstable++;
            if (mem_req_valid && hs == int'(v.stall_idx) && stall_cnt < int'(v.stall_len)) begin
                mem_req_ready = 1'b0; stall_cnt++;
                prev_valid = 1'b1; prev_addr = mem_req_addr;
            end else begin
                mem_req_ready = 1'b1; prev_valid = 1'b0;
                if (mem_req_valid) begin
                    if (hs < 4) reqs[hs] = mem_req_addr;
                    hs++;
                end
            end
        end
        miss_req = 1'b0;
        check("fill_count", 153'(fills), 153'(1));
        check("fill_cycle", 153'(fill_cyc), 153'(v.exp_cyc));
        check("fill_set", 153'(got_set), 153'(v.exp_set));
        check("fill_line", got_line, v.exp_line);
        check("handshake_count", 153'(hs), 153'(4));
        check("req_addr_stable", 153'(unstable), 153'(0));
        for (int k = 0; k < 4; k++) check($sformatf("req_addr_%0d", k), 153'(reqs[k]), 153'(v.exp_req[k]));
`ifdef CRITICAL_WORD_FIRST_EN
        check("crit_count", 153'(crits), 153'(1));
        check("crit_cycle", 153'(crit_cyc), 153'(3));
        check("crit_data", 153'(got_crit), 153'(v.exp_crit));
`else
        check("crit_count", 153'(crits), 153'(0));
        check("crit_data_zero", 153'(crit_data), 153'(0));
`endif
    endtask

    initial begin
        int hs, bad;
`ifdef CRITICAL_WORD_FIRST_EN
        vecs[0] = '{32'h0001_0034, 8'd9, 8'd0, 8'd9, 4'h3,
                    {1'b1, 24'h000100, 32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030},
                    {32'h00010030, 32'h0001003C, 32'h00010038, 32'h00010034}, 32'h00010034};
        vecs[1] = '{32'h0001_0034, 8'd1, 8'd5, 8'd14, 4'h3,
                    {1'b1, 24'h000100, 32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030},
                    {32'h00010030, 32'h0001003C, 32'h00010038, 32'h00010034}, 32'h00010034};
        vecs[2] = '{32'hABCD_EF3B, 8'd9, 8'd0, 8'd9, 4'h3,
                    {1'b1, 24'hABCDEF, 32'hABCDEF3C, 32'hABCDEF38, 32'hABCDEF34, 32'hABCDEF30},
                    {32'hABCDEF34, 32'hABCDEF30, 32'hABCDEF3C, 32'hABCDEF38}, 32'hABCDEF38};
        vecs[3] = '{32'hFFFF_FFFC, 8'd9, 8'd0, 8'd9, 4'hF,
                    {1'b1, 24'hFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF4, 32'hFFFFFFF0},
                    {32'hFFFFFFF8, 32'hFFFFFFF4, 32'hFFFFFFF0, 32'hFFFFFFFC}, 32'hFFFFFFFC};
        vecs[4] = '{32'h0000_0000, 8'd9, 8'd0, 8'd9, 4'h0,
                    {1'b1, 24'h000000, 32'h0000000C, 32'h00000008, 32'h00000004, 32'h00000000},
                    {32'h0000000C, 32'h00000008, 32'h00000004, 32'h00000000}, 32'h00000000};
        vecs[5] = '{32'h0001_0034, 8'd3, 8'd2, 8'd11, 4'h3,
                    {1'b1, 24'h000100, 32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030},
                    {32'h00010030, 32'h0001003C, 32'h00010038, 32'h00010034}, 32'h00010034};
`else
        vecs[0] = '{32'h0001_0034, 8'd9, 8'd0, 8'd9, 4'h3,
                    {1'b1, 24'h000100, 32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030},
                    {32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030}, 32'h0};
        vecs[1] = '{32'h0001_0034, 8'd1, 8'd5, 8'd14, 4'h3,
                    {1'b1, 24'h000100, 32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030},
                    {32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030}, 32'h0};
        vecs[2] = '{32'hABCD_EF3B, 8'd9, 8'd0, 8'd9, 4'h3,
                    {1'b1, 24'hABCDEF, 32'hABCDEF3C, 32'hABCDEF38, 32'hABCDEF34, 32'hABCDEF30},
                    {32'hABCDEF3C, 32'hABCDEF38, 32'hABCDEF34, 32'hABCDEF30}, 32'h0};
        vecs[3] = '{32'hFFFF_FFFC, 8'd9, 8'd0, 8'd9, 4'hF,
                    {1'b1, 24'hFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF4, 32'hFFFFFFF0},
                    {32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF4, 32'hFFFFFFF0}, 32'h0};
        vecs[4] = '{32'h0000_0000, 8'd9, 8'd0, 8'd9, 4'h0,
                    {1'b1, 24'h000000, 32'h0000000C, 32'h00000008, 32'h00000004, 32'h00000000},
                    {32'h0000000C, 32'h00000008, 32'h00000004, 32'h00000000}, 32'h0};
        vecs[5] = '{32'h0001_0034, 8'd3, 8'd2, 8'd11, 4'h3,
                    {1'b1, 24'h000100, 32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030},
                    {32'h0001003C, 32'h00010038, 32'h00010034, 32'h00010030}, 32'h0};
`endif

        // Reset values while rst_n is held low.
        rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        #12;
        check("rst_busy", 153'(busy), 153'(0));
        check("rst_req_valid", 153'(mem_req_valid), 153'(0));
        check("rst_fill_valid", 153'(fill_valid), 153'(0));
        check("rst_fill_set", 153'(fill_set), 153'(0));
        check("rst_fill_line", fill_line, 153'(0));
        check("rst_crit", 153'({crit_valid, crit_data}), 153'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_refill(vecs[i], 1'b0, 32'h0, 32'h0);

        // miss_req held high with a changing address, rsp_valid high in ISSUE.
`ifdef CRITICAL_WORD_FIRST_EN
        run_refill(vecs[0], 1'b1, 32'h2000_0054, 32'h2000_0054);
`else
        run_refill(vecs[0], 1'b1, 32'h2000_0054, 32'h2000_0050);
`endif
        do_reset();

        // Reset while waiting for the response of the third request.
        @(negedge clk);
        miss_req = 1'b1; miss_addr = 32'h0001_0034; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        hs = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            miss_req = 1'b0;
            if (mem_req_valid) hs++;
            if (hs == 3) begin
                mem_rsp_valid = 1'b0;
                break;
            end
        end
        check("mid_reset_reached_word2", 153'(hs), 153'(3));
        repeat (2) @(negedge clk);
        check("mid_reset_busy_before", 153'(busy), 153'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_busy", 153'(busy), 153'(0));
        check("mid_reset_req_valid", 153'(mem_req_valid), 153'(0));
        check("mid_reset_fill", 153'({fill_valid, fill_set, fill_line}), 153'(0));
        @(negedge clk);
        rst_n = 1'b1; mem_rsp_valid = 1'b1;
        bad = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (fill_valid || busy || mem_req_valid || crit_valid) bad++;
        end
        check("stray_rsp_ignored", 153'(bad), 153'(0));
        mem_rsp_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory word width.
- SET_BITS, 4, cache set index width; line = 4 words, tag = ADDR_WIDTH-8.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- miss_req, in, 1, cache miss request, sampled only in IDLE.
- miss_addr, in, ADDR_WIDTH, missing byte address: [31:8] tag, [7:4] set, [3:2] word.
- busy, out, 1, high in any state other than IDLE.
- mem_req_valid, out, 1, word read request to backing RAM.
- mem_req_addr, out, ADDR_WIDTH, word-aligned read address, [1:0]=00.
- mem_req_ready, in, 1, RAM accepts request.
- mem_rsp_valid, in, 1, read data valid.
- mem_rsp_data, in, DATA_WIDTH, read data.
- fill_valid, out, 1, one-cycle pulse: completed line ready to write.
- fill_set, out, SET_BITS, target cache set.
- fill_line, out, 153, {1'b1 valid, tag[23:0], w3, w2, w1, w0}.
- crit_valid, out, 1, one-cycle pulse: requested word available early.
- crit_data, out, DATA_WIDTH, requested word.
REQ-003 SHALL use one clock (clk) with asynchronous active-low reset (rst_n).

Function
REQ-004 SHALL implement FSM IDLE -> ISSUE -> RESP -> (ISSUE | DONE) -> IDLE.
REQ-005 IDLE with miss_req=1 SHALL latch miss_addr, clear word count, enter ISSUE; miss_req outside IDLE SHALL be ignored.
REQ-006 ISSUE SHALL hold mem_req_valid=1 with stable mem_req_addr until mem_req_ready=1, then enter RESP.
REQ-007 RESP SHALL wait for mem_rsp_valid; on it, store mem_rsp_data into word slot mem_req_addr[3:2] and increment count; count reaching 4 -> DONE, else ISSUE.
REQ-008 mem_rsp_valid outside RESP SHALL be ignored; only one request outstanding at any time.
REQ-009 mem_req_addr SHALL be {tag, set, word_idx, 2'b00}; miss_addr[1:0] ignored.
REQ-010 Default word order SHALL be 0,1,2,3.
REQ-011 DONE SHALL assert fill_valid for exactly one cycle with fill_set and fill_line valid that cycle, then return to IDLE.
REQ-012 Minimum latency with ready and response always asserted SHALL be: accept at edge 0, fill_valid high in cycle 9.
REQ-013 fill_line, fill_set SHALL hold last value outside DONE; consumers sample only on fill_valid.
REQ-014 Word count SHALL be 2 bits plus done flag; word index SHALL wrap modulo 4.

Reset
REQ-015 rst_n low SHALL force IDLE, busy=0, mem_req_valid=0, fill_valid=0, crit_valid=0, fill_set=0, fill_line=0, crit_data=0 asynchronously.
REQ-016 Reset mid-refill SHALL discard partial line; responses arriving after release while IDLE SHALL be ignored.

Configuration
REQ-017 Macro CRITICAL_WORD_FIRST_EN defined: word order SHALL start at miss_addr[3:2] and wrap (e.g. 2,3,0,1); crit_valid SHALL pulse with crit_data in the cycle after the first response is accepted.
REQ-018 Macro undefined: order per REQ-010; crit_valid and crit_data SHALL be tied 0.

Structure
REQ-019 Shared package cache_pkg SHALL hold line width (153), tag/set/offset widths, packed cache-line typedef, FSM state enum.
REQ-020 Sub-module refill_line_buf (4-word assembly register, indexed write, clear) is natural; FSM and address generation stay in the top.

Verification
REQ-021 Miss at 0x0001_0034, ready/rsp always 1, RAM word = address -> requests 0x...30,34,38,3C; fill_valid cycle 9, fill_set=3, fill_line={1,0x000100,0x1003C,0x10038,0x10034,0x10030}.
REQ-022 mem_req_ready low 5 cycles on word 1 -> mem_req_addr stable throughout, single handshake, fill_valid delayed by 5.
REQ-023 With CRITICAL_WORD_FIRST_EN, miss at 0x...38 -> order 38,3C,30,34; crit_valid once, crit_data=word at 0x38; line slots correct.
REQ-024 rst_n low during RESP of word 2 -> all outputs 0 immediately; stray mem_rsp_valid after release -> no fill_valid, FSM stays IDLE.
REQ-025 miss_req held high during refill plus spurious mem_rsp_valid in ISSUE -> ignored; exactly one fill_valid; new miss accepted in first IDLE cycle.
